muldiv_iter_unit: RTL and testbench
===================================

// Module: muldiv_iter_unit
// PURPOSE
//  Multi-cycle multiply/divide responder for the EX stage. EX raises ena and holds the pipeline
//  while the operation runs; this block runs a radix-2 iterative engine (1 bit per cycle) and
//  pulses finish when {oHI,oLO} is valid. EX owns the rule that ena always reflects the
//  instruction currently in EX, and advances that instruction on finish.
// PARAMETERS
//  WIDTH  32  operand width; iteration count = WIDTH; counter width = $clog2(WIDTH)+1
// PORTS
//  clk        in   1      clock; every register updates on posedge
//  reset      in   1      synchronous, active-high
//  ena        in   1      op request (level); sampled only in IDLE/DONE, abort if low in BUSY
//  calc       in   2      00 MULT, 01 MULTU, 10 DIV, 11 DIVU
//  a          in   WIDTH  multiplicand / dividend
//  b          in   WIDTH  multiplier / divisor
//  cpu_stall  in   1      global freeze: no state, counter or output update while high
//  busy       out  1      high while state==BUSY
//  finish     out  1      high for exactly one cycle (state==DONE); results valid
//  oHI        out  WIDTH  MULT*: product[63:32]; DIV*: remainder
//  oLO        out  WIDTH  MULT*: product[31:0];  DIV*: quotient
// BEHAVIOUR
//  Reset: state=IDLE, count=0, busy=0, finish=0, oHI=oLO=0. Reset wins over every other input.
//  States: IDLE, BUSY, DONE.
//   IDLE: on an edge with ena && !cpu_stall, latch a, b, calc. Signed ops latch magnitudes plus
//         result sign flags. count=0. Go to BUSY. Call this edge E0.
//   BUSY: one iteration per edge. Multiply = shift-add. Divide = restoring shift-subtract.
//         count increments each iteration. The iteration at edge E_WIDTH is the last one; it
//         writes oHI/oLO (sign fixup applied) and goes to DONE.
//         If ena==0 && !cpu_stall at an edge: abort to IDLE. oHI/oLO keep their previous
//         values and finish is never raised.
//   DONE: finish=1 for this one cycle. The next edge behaves exactly like IDLE: if ena is
//         high, accept a new op (EX has already advanced), otherwise go to IDLE.
//  Latency: accept at E0; finish high from E_WIDTH to E_WIDTH+1 (E32..E33 when WIDTH=32).
//   Back-to-back ops: the next accept can happen at E_WIDTH+1.
//  cpu_stall high: the whole block holds, including accept and abort. Each stalled cycle adds
//   exactly one cycle to latency. A stall during DONE holds finish high.
//  Outputs are registered and change only at completion or reset. They hold between ops.
//  Arithmetic rules:
//   MULT: {oHI,oLO} = signed 64-bit a*b.
//   MULTU: {oHI,oLO} = unsigned 64-bit a*b.
//   DIV: quotient truncates toward zero; remainder takes the sign of the dividend.
//   DIVU: unsigned quotient and remainder.
//   Divide by zero (DIV or DIVU): oLO = all ones, oHI = a. Still takes the full WIDTH cycles.
//   DIV 0x80000000 / 0xFFFFFFFF: oLO = 0x80000000, oHI = 0 (no trap).
//  calc, a, b changing after E0 have no effect on the running op.
// TESTING
//  1 MULTU a=FFFFFFFF b=FFFFFFFF -> HI=FFFFFFFE LO=00000001; finish exactly at E32, high for
//    1 cycle; busy high E0..E32.
//  2 MULT a=FFFFFFFD(-3) b=7 -> HI=FFFFFFFF LO=FFFFFFEB. DIVU 100/7 -> LO=0000000E HI=00000002.
//  3 DIV a=FFFFFFF9(-7) b=2 -> LO=FFFFFFFD HI=FFFFFFFF. DIV 7/-2 -> LO=FFFFFFFD HI=00000001.
//  4 DIVU 5/0 -> LO=FFFFFFFF HI=00000005. DIV 80000000/FFFFFFFF -> LO=80000000 HI=0.
//    Both finish at E32.
//  5 cpu_stall high 5 cycles at iteration 10 -> same results, finish at E37. Stall during DONE
//    holds finish high. ena held high after finish -> second op accepted at E33, finish at E65.
//  6 ena low at iteration 10 -> IDLE, no finish, outputs keep prior op. reset at iteration 20
//    -> next cycle busy=0, HI=LO=0, finish never pulses.

Source files
------------

// File: rtl/muldiv_iter_unit.sv
// ---------------------------------------------------------------------------
// muldiv_iter_unit
//
// Multi-cycle multiply/divide responder for the EX stage. EX raises ena and
// holds the pipeline. A radix-2 engine then retires one bit per clock:
// shift-add for multiply and restoring shift-subtract for divide. finish
// pulses for one cycle when {oHI,oLO} holds the result.
//
// Ports
//   clk        clock; every register updates on the rising edge
//   reset      synchronous, active-high; wins over every other input
//   ena        operation request (level); dropping it while busy aborts
//   calc       00 MULT, 01 MULTU, 10 DIV, 11 DIVU
//   a          multiplicand / dividend
//   b          multiplier / divisor
//   cpu_stall  global freeze; nothing changes while it is high
//   busy       high while an operation is iterating
//   finish     high for exactly one cycle (longer under stall); result valid
//   oHI        MULT*: upper product half   DIV*: remainder
//   oLO        MULT*: lower product half   DIV*: quotient
// ---------------------------------------------------------------------------
module muldiv_iter_unit #(
    parameter int WIDTH = 32
) (
    input  logic             clk,
    input  logic             reset,
    input  logic             ena,
    input  logic [1:0]       calc,
    input  logic [WIDTH-1:0] a,
    input  logic [WIDTH-1:0] b,
    input  logic             cpu_stall,
    output logic             busy,
    output logic             finish,
    output logic [WIDTH-1:0] oHI,
    output logic [WIDTH-1:0] oLO
);

    localparam int CW = $clog2(WIDTH) + 1;

    typedef enum logic [1:0] {
        IDLE,
        BUSY,
        DONE
    } state_t;

    state_t           state, state_nxt;
    logic [CW-1:0]    count, count_nxt;
    logic [WIDTH-1:0] acc_hi, acc_hi_nxt;
    logic [WIDTH-1:0] acc_lo, acc_lo_nxt;
    logic [WIDTH-1:0] opnd, opnd_nxt;
    logic             op_div, op_div_nxt;
    logic             neg_q, neg_q_nxt;
    logic             neg_r, neg_r_nxt;
    logic             div_zero, div_zero_nxt;
    logic [WIDTH-1:0] out_hi_nxt, out_lo_nxt;

    // Operand conditioning for the accept edge. The engine only ever works
    // on magnitudes; signed ops record the result signs separately.
    logic             signed_op;
    logic             a_neg, b_neg;
    logic [WIDTH-1:0] a_mag, b_mag;

    always_comb begin
        signed_op = ~calc[0];
        a_neg     = signed_op & a[WIDTH-1];
        b_neg     = signed_op & b[WIDTH-1];
        a_mag     = a_neg ? (~a + 1'b1) : a;
        b_mag     = b_neg ? (~b + 1'b1) : b;
    end

    // One iteration of the engine, computed from the current accumulators.
    // Multiply: acc_lo holds the remaining multiplier bits and shifts right
    // while the partial sum grows in acc_hi. Divide: acc_lo holds the
    // dividend, shifting left into acc_hi while quotient bits fill in from
    // the right. The borrow bit of the trial subtraction decides whether the
    // subtraction is kept.
    logic [WIDTH:0]     mult_sum;
    logic [WIDTH:0]     div_shift;
    logic [WIDTH:0]     div_diff;
    logic               div_ge;
    logic [WIDTH-1:0]   iter_hi, iter_lo;
    logic [2*WIDTH-1:0] prod_fix;
    logic [WIDTH-1:0]   quot_fix, rem_fix;
    logic               last_iter;

    always_comb begin
        mult_sum  = {1'b0, acc_hi} + (acc_lo[0] ? {1'b0, opnd} : {(WIDTH+1){1'b0}});
        div_shift = {acc_hi, acc_lo[WIDTH-1]};
        div_diff  = div_shift - {1'b0, opnd};
        div_ge    = ~div_diff[WIDTH];
        if (op_div) begin
            iter_hi = div_ge ? div_diff[WIDTH-1:0] : div_shift[WIDTH-1:0];
            iter_lo = {acc_lo[WIDTH-2:0], div_ge};
        end else begin
            iter_hi = mult_sum[WIDTH:1];
            iter_lo = {mult_sum[0], acc_lo[WIDTH-1:1]};
        end
        last_iter = (count == CW'(WIDTH - 1));
    end

    // Sign fixup applied to the final iteration's outcome. A zero divisor
    // leaves the whole dividend magnitude in the remainder, so restoring the
    // dividend sign hands back the original a; only the quotient needs the
    // all-ones override.
    always_comb begin
        prod_fix = neg_q ? (~{iter_hi, iter_lo} + 1'b1) : {iter_hi, iter_lo};
        rem_fix  = neg_r ? (~iter_hi + 1'b1) : iter_hi;
        if (div_zero) begin
            quot_fix = {WIDTH{1'b1}};
        end else begin
            quot_fix = neg_q ? (~iter_lo + 1'b1) : iter_lo;
        end
    end

    // Next-state and datapath control. IDLE and DONE share the accept
    // behaviour so a held ena starts the next op right after finish. A high
    // cpu_stall simply leaves every default (hold) in place.
    always_comb begin
        state_nxt    = state;
        count_nxt    = count;
        acc_hi_nxt   = acc_hi;
        acc_lo_nxt   = acc_lo;
        opnd_nxt     = opnd;
        op_div_nxt   = op_div;
        neg_q_nxt    = neg_q;
        neg_r_nxt    = neg_r;
        div_zero_nxt = div_zero;
        out_hi_nxt   = oHI;
        out_lo_nxt   = oLO;

        if (!cpu_stall) begin
            case (state)
                IDLE, DONE: begin
                    if (ena) begin
                        state_nxt    = BUSY;
                        count_nxt    = '0;
                        op_div_nxt   = calc[1];
                        neg_q_nxt    = a_neg ^ b_neg;
                        neg_r_nxt    = calc[1] & a_neg;
                        div_zero_nxt = calc[1] & (b == '0);
                        acc_hi_nxt   = '0;
                        acc_lo_nxt   = calc[1] ? a_mag : b_mag;
                        opnd_nxt     = calc[1] ? b_mag : a_mag;
                    end else begin
                        state_nxt = IDLE;
                    end
                end
                BUSY: begin
                    if (!ena) begin
                        state_nxt = IDLE;
                    end else begin
                        acc_hi_nxt = iter_hi;
                        acc_lo_nxt = iter_lo;
                        count_nxt  = count + CW'(1);
                        if (last_iter) begin
                            state_nxt = DONE;
                            if (op_div) begin
                                out_hi_nxt = rem_fix;
                                out_lo_nxt = quot_fix;
                            end else begin
                                out_hi_nxt = prod_fix[2*WIDTH-1:WIDTH];
                                out_lo_nxt = prod_fix[WIDTH-1:0];
                            end
                        end
                    end
                end
                default: begin
                    state_nxt = IDLE;
                end
            endcase
        end
    end

    // State, engine and result registers. Reset clears everything visible so
    // a reset mid-operation shows zero results and no finish.
    always_ff @(posedge clk) begin
        if (reset) begin
            state    <= IDLE;
            count    <= '0;
            acc_hi   <= '0;
            acc_lo   <= '0;
            opnd     <= '0;
            op_div   <= 1'b0;
            neg_q    <= 1'b0;
            neg_r    <= 1'b0;
            div_zero <= 1'b0;
            oHI      <= '0;
            oLO      <= '0;
        end else begin
            state    <= state_nxt;
            count    <= count_nxt;
            acc_hi   <= acc_hi_nxt;
            acc_lo   <= acc_lo_nxt;
            opnd     <= opnd_nxt;
            op_div   <= op_div_nxt;
            neg_q    <= neg_q_nxt;
            neg_r    <= neg_r_nxt;
            div_zero <= div_zero_nxt;
            oHI      <= out_hi_nxt;
            oLO      <= out_lo_nxt;
        end
    end

    // Status flags come straight from the registered state.
    always_comb begin
        busy   = (state == BUSY);
        finish = (state == DONE);
    end

endmodule

// File: tb/tb_muldiv_iter_unit.sv
// ---------------------------------------------------------------------------
// tb_muldiv_iter_unit
//
// Self-checking bench for muldiv_iter_unit. Directed vectors with fixed
// answers, randomized operations against a plain-arithmetic reference,
// stall, back-to-back, abort and mid-operation reset scenarios.
// ---------------------------------------------------------------------------
module tb_muldiv_iter_unit;

    localparam int WIDTH = 32;

    logic        clk = 1'b0;
    logic        reset;
    logic        ena;
    logic [1:0]  calc;
    logic [31:0] a;
    logic [31:0] b;
    logic        cpu_stall;
    logic        busy;
    logic        finish;
    logic [31:0] oHI;
    logic [31:0] oLO;

    int tests_run    = 0;
    int tests_failed = 0;

    muldiv_iter_unit #(.WIDTH(WIDTH)) dut (
        .clk       (clk),
        .reset     (reset),
        .ena       (ena),
        .calc      (calc),
        .a         (a),
        .b         (b),
        .cpu_stall (cpu_stall),
        .busy      (busy),
        .finish    (finish),
        .oHI       (oHI),
        .oLO       (oLO)
    );

    // Free-running clock, 10 time units per period.
    always #5 clk = ~clk;

    // Watchdog so the run always ends even if a wait escapes its bound.
    initial begin
        #1000000;
        $display("[TB] FAIL watchdog: simulation time limit reached");
        $fatal(1, "[TB] watchdog expired");
    end

    // Reference result straight from the arithmetic rules: 64-bit products,
    // truncating division, remainder signed like the dividend, and the two
    // special divide cases.
    function automatic logic [63:0] ref_model(input logic [1:0] op,
                                              input logic [31:0] x,
                                              input logic [31:0] y);
        longint      sx;
        longint      sy;
        logic [63:0] ux;
        logic [63:0] uy;
        logic [63:0] r;
        int          q;
        int          m;
        sx = longint'($signed(x));
        sy = longint'($signed(y));
        ux = {32'b0, x};
        uy = {32'b0, y};
        r  = '0;
        case (op)
            2'b00: r = 64'(sx * sy);
            2'b01: r = ux * uy;
            2'b10: begin
                if (y == 32'h0) begin
                    r = {x, 32'hFFFF_FFFF};
                end else if (x == 32'h8000_0000 && y == 32'hFFFF_FFFF) begin
                    r = {32'h0, 32'h8000_0000};
                end else begin
                    q = $signed(x) / $signed(y);
                    m = $signed(x) % $signed(y);
                    r = {32'(m), 32'(q)};
                end
            end
            default: begin
                if (y == 32'h0) begin
                    r = {x, 32'hFFFF_FFFF};
                end else begin
                    r = {x % y, x / y};
                end
            end
        endcase
        return r;
    endfunction

    // Drives one operation from the current time: the next edge is E0. After
    // E0 the inputs are scrambled to show they no longer matter. Reports the
    // edge index (relative to E0) at which finish was first seen, the
    // results, and how many BUSY cycles showed busy low. An optional stall
    // window freezes edges stall_at+1 .. stall_at+stall_len.
    task automatic run_op(input logic [1:0] op, input logic [31:0] x,
                          input logic [31:0] y, input int stall_at,
                          input int stall_len, output int lat,
                          output logic [31:0] hi, output logic [31:0] lo,
                          output int busy_bad);
        calc = op;
        a    = x;
        b    = y;
        ena  = 1'b1;
        @(posedge clk);
        #1;
        busy_bad = (busy !== 1'b1) ? 1 : 0;
        lat      = -1;
        a        = $urandom;
        b        = $urandom;
        calc     = 2'($urandom_range(0, 3));
        if (stall_len > 0 && stall_at == 0) cpu_stall = 1'b1;
        for (int k = 1; k <= 200; k++) begin
            @(posedge clk);
            #1;
            if (finish === 1'b1) begin
                lat = k;
                break;
            end
            if (busy !== 1'b1) busy_bad++;
            if (stall_len > 0 && k == stall_at) cpu_stall = 1'b1;
            if (stall_len > 0 && k == stall_at + stall_len) cpu_stall = 1'b0;
        end
        cpu_stall = 1'b0;
        hi = oHI;
        lo = oLO;
    endtask

    task automatic test_reset();
        reset     = 1'b1;
        ena       = 1'b1;
        cpu_stall = 1'b0;
        calc      = 2'b01;
        a         = 32'h1234_5678;
        b         = 32'h9ABC_DEF0;
        repeat (3) @(posedge clk);
        #1;
        tests_run++;
        if (busy !== 1'b0) begin
            tests_failed++;
            $display("[TB] FAIL reset_busy: got %b expected 0", busy);
        end
        tests_run++;
        if (finish !== 1'b0) begin
            tests_failed++;
            $display("[TB] FAIL reset_finish: got %b expected 0", finish);
        end
        tests_run++;
        if (oHI !== 32'h0 || oLO !== 32'h0) begin
            tests_failed++;
            $display("[TB] FAIL reset_outputs: got %h_%h expected 0_0", oHI, oLO);
        end
        ena   = 1'b0;
        reset = 1'b0;
        @(posedge clk);
        #1;
    endtask

    task automatic test_directed();
        logic [1:0]  ops [7]  = '{2'b01, 2'b00, 2'b11, 2'b10, 2'b10, 2'b11, 2'b10};
        logic [31:0] xs  [7]  = '{32'hFFFF_FFFF, 32'hFFFF_FFFD, 32'd100, 32'hFFFF_FFF9,
                                  32'd7, 32'd5, 32'h8000_0000};
        logic [31:0] ys  [7]  = '{32'hFFFF_FFFF, 32'd7, 32'd7, 32'd2,
                                  32'hFFFF_FFFE, 32'd0, 32'hFFFF_FFFF};
        logic [63:0] exp [7]  = '{64'hFFFF_FFFE_0000_0001, 64'hFFFF_FFFF_FFFF_FFEB,
                                  64'h0000_0002_0000_000E, 64'hFFFF_FFFF_FFFF_FFFD,
                                  64'h0000_0001_FFFF_FFFD, 64'h0000_0005_FFFF_FFFF,
                                  64'h0000_0000_8000_0000};
        int          lat;
        int          busy_bad;
        logic [31:0] hi;
        logic [31:0] lo;
        for (int i = 0; i < 7; i++) begin
            run_op(ops[i], xs[i], ys[i], 0, 0, lat, hi, lo, busy_bad);
            tests_run++;
            if (lat != WIDTH) begin
                tests_failed++;
                $display("[TB] FAIL directed%0d_latency: got %0d expected %0d", i, lat, WIDTH);
            end
            tests_run++;
            if ({hi, lo} !== exp[i]) begin
                tests_failed++;
                $display("[TB] FAIL directed%0d_result: got %h_%h expected %h", i, hi, lo, exp[i]);
            end
            tests_run++;
            if (busy_bad != 0) begin
                tests_failed++;
                $display("[TB] FAIL directed%0d_busy: got %0d low cycles expected 0", i, busy_bad);
            end
            ena = 1'b0;
            @(posedge clk);
            #1;
            tests_run++;
            if (finish !== 1'b0 || busy !== 1'b0) begin
                tests_failed++;
                $display("[TB] FAIL directed%0d_pulse: got finish=%b busy=%b expected 0 0",
                         i, finish, busy);
            end
        end
    endtask

    task automatic test_random();
        logic [1:0]  op;
        logic [31:0] x;
        logic [31:0] y;
        logic [63:0] expv;
        int          lat;
        int          busy_bad;
        int          sel;
        logic [31:0] hi;
        logic [31:0] lo;
        for (int i = 0; i < 30; i++) begin
            op  = 2'($urandom_range(0, 3));
            x   = $urandom;
            y   = $urandom;
            sel = $urandom_range(0, 7);
            if (sel == 0) y = 32'h0;
            if (sel == 1) begin
                x = 32'h8000_0000;
                y = 32'hFFFF_FFFF;
            end
            if (sel == 2) y = 32'($urandom_range(1, 20));
            if (sel == 3) y = -32'($urandom_range(1, 20));
            expv = ref_model(op, x, y);
            run_op(op, x, y, 0, 0, lat, hi, lo, busy_bad);
            tests_run++;
            if (lat != WIDTH || {hi, lo} !== expv) begin
                tests_failed++;
                $display("[TB] FAIL random%0d op=%0d a=%h b=%h: got %h_%h lat %0d expected %h lat %0d",
                         i, op, x, y, hi, lo, lat, expv, WIDTH);
            end
            ena = 1'b0;
            @(posedge clk);
            #1;
        end
    endtask

    task automatic test_stall();
        int          lat;
        int          busy_bad;
        logic [31:0] hi;
        logic [31:0] lo;
        run_op(2'b11, 32'd100, 32'd7, 10, 5, lat, hi, lo, busy_bad);
        tests_run++;
        if (lat != WIDTH + 5) begin
            tests_failed++;
            $display("[TB] FAIL stall_latency: got %0d expected %0d", lat, WIDTH + 5);
        end
        tests_run++;
        if (hi !== 32'd2 || lo !== 32'd14) begin
            tests_failed++;
            $display("[TB] FAIL stall_result: got %h_%h expected 00000002_0000000e", hi, lo);
        end
        tests_run++;
        if (busy_bad != 0) begin
            tests_failed++;
            $display("[TB] FAIL stall_busy: got %0d low cycles expected 0", busy_bad);
        end
        cpu_stall = 1'b1;
        ena       = 1'b0;
        for (int k = 0; k < 3; k++) begin
            @(posedge clk);
            #1;
            tests_run++;
            if (finish !== 1'b1 || oHI !== 32'd2 || oLO !== 32'd14) begin
                tests_failed++;
                $display("[TB] FAIL stall_done%0d: got finish=%b %h_%h expected 1 00000002_0000000e",
                         k, finish, oHI, oLO);
            end
        end
        cpu_stall = 1'b0;
        @(posedge clk);
        #1;
        tests_run++;
        if (finish !== 1'b0 || busy !== 1'b0) begin
            tests_failed++;
            $display("[TB] FAIL stall_release: got finish=%b busy=%b expected 0 0", finish, busy);
        end
    endtask

    task automatic test_back_to_back();
        int          lat1;
        int          lat2;
        int          bb1;
        int          bb2;
        logic [31:0] hi1;
        logic [31:0] lo1;
        logic [31:0] hi2;
        logic [31:0] lo2;
        logic [31:0] x2;
        logic [31:0] y2;
        logic [63:0] exp2;
        x2   = $urandom;
        y2   = $urandom;
        exp2 = ref_model(2'b00, x2, y2);
        run_op(2'b10, 32'hFFFF_FFF9, 32'd2, 0, 0, lat1, hi1, lo1, bb1);
        run_op(2'b00, x2, y2, 0, 0, lat2, hi2, lo2, bb2);
        tests_run++;
        if (lat1 + 1 + lat2 != 2 * WIDTH + 1) begin
            tests_failed++;
            $display("[TB] FAIL b2b_total_latency: got %0d expected %0d",
                     lat1 + 1 + lat2, 2 * WIDTH + 1);
        end
        tests_run++;
        if (hi1 !== 32'hFFFF_FFFF || lo1 !== 32'hFFFF_FFFD) begin
            tests_failed++;
            $display("[TB] FAIL b2b_first: got %h_%h expected ffffffff_fffffffd", hi1, lo1);
        end
        tests_run++;
        if ({hi2, lo2} !== exp2) begin
            tests_failed++;
            $display("[TB] FAIL b2b_second: got %h_%h expected %h", hi2, lo2, exp2);
        end
        tests_run++;
        if (bb1 != 0 || bb2 != 0) begin
            tests_failed++;
            $display("[TB] FAIL b2b_busy: got %0d/%0d low cycles expected 0/0", bb1, bb2);
        end
        ena = 1'b0;
        @(posedge clk);
        #1;
    endtask

    task automatic test_abort();
        int          lat;
        int          busy_bad;
        int          seen;
        logic [31:0] hi;
        logic [31:0] lo;
        run_op(2'b01, 32'd3, 32'd5, 0, 0, lat, hi, lo, busy_bad);
        ena = 1'b0;
        @(posedge clk);
        #1;
        calc = 2'b11;
        a    = $urandom;
        b    = $urandom_range(1, 1000);
        ena  = 1'b1;
        repeat (11) @(posedge clk);
        #1;
        ena = 1'b0;
        @(posedge clk);
        #1;
        tests_run++;
        if (busy !== 1'b0 || finish !== 1'b0) begin
            tests_failed++;
            $display("[TB] FAIL abort_state: got busy=%b finish=%b expected 0 0", busy, finish);
        end
        seen = 0;
        for (int k = 0; k < 40; k++) begin
            @(posedge clk);
            #1;
            if (finish === 1'b1) seen++;
        end
        tests_run++;
        if (seen != 0) begin
            tests_failed++;
            $display("[TB] FAIL abort_no_finish: got %0d finish cycles expected 0", seen);
        end
        tests_run++;
        if (oHI !== 32'd0 || oLO !== 32'd15) begin
            tests_failed++;
            $display("[TB] FAIL abort_outputs: got %h_%h expected 00000000_0000000f", oHI, oLO);
        end
    endtask

    task automatic test_reset_mid();
        int seen;
        calc = 2'b00;
        a    = 32'hDEAD_BEEF;
        b    = 32'h1357_9BDF;
        ena  = 1'b1;
        repeat (21) @(posedge clk);
        #1;
        reset = 1'b1;
        @(posedge clk);
        #1;
        tests_run++;
        if (busy !== 1'b0 || finish !== 1'b0 || oHI !== 32'h0 || oLO !== 32'h0) begin
            tests_failed++;
            $display("[TB] FAIL reset_mid: got busy=%b finish=%b %h_%h expected 0 0 0_0",
                     busy, finish, oHI, oLO);
        end
        reset = 1'b0;
        ena   = 1'b0;
        seen  = 0;
        for (int k = 0; k < 40; k++) begin
            @(posedge clk);
            #1;
            if (finish === 1'b1) seen++;
        end
        tests_run++;
        if (seen != 0) begin
            tests_failed++;
            $display("[TB] FAIL reset_mid_no_finish: got %0d finish cycles expected 0", seen);
        end
    endtask

    initial begin
        test_reset();
        test_directed();
        test_random();
        test_stall();
        test_back_to_back();
        test_abort();
        test_reset_mid();
        $display("[TB] %0d tests run, %0d failed", tests_run, tests_failed);
        $finish;
    end

endmodule
